sg_monitor: RTL and testbench

SG_MONITOR -- requirements
Module: sg_monitor

---
 rtl/sg_mon_pkg.sv | 61 ++++++
 rtl/sg_trans_lookup.sv | 51 +++++
 rtl/sg_monitor.sv | 165 ++++++++++++++++
 tb/tb_sg_monitor.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sg_mon_pkg.sv
// sg_monitor shared definitions: entry layout, field widths,
// direction encodings and entry pack/unpack helpers.
package sg_mon_pkg;

  localparam logic DIR_RISE = 1'b1;
  localparam logic DIR_FALL = 1'b0;

  localparam int FLD_W = 16;
  localparam int RAW_W = 64;

  typedef logic [RAW_W-1:0] ent_raw_t;

  typedef struct packed {
    logic             valid;
    logic [FLD_W-1:0] from;
    logic [FLD_W-1:0] idx;
    logic             dir;
    logic [FLD_W-1:0] to;
  } ent_t;

  function automatic int state_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int sig_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ent_w(input int sw, input int gw);
    return 2 * sw + gw + 2;
  endfunction

  function automatic ent_raw_t fmask(input int w);
    return (ent_raw_t'(1) << w) - ent_raw_t'(1);
  endfunction

  function automatic ent_raw_t ent_pack(input ent_t e,
                                        input int sw,
                                        input int gw);
    ent_raw_t r;
    r = ent_raw_t'(e.to) & fmask(sw);
    r = r | (ent_raw_t'(e.dir) << sw);
    r = r | ((ent_raw_t'(e.idx) & fmask(gw)) << (sw + 1));
    r = r | ((ent_raw_t'(e.from) & fmask(sw)) << (sw + 1 + gw));
    r = r | (ent_raw_t'(e.valid) << (2 * sw + 1 + gw));
    return r;
  endfunction

  function automatic ent_t ent_unpack(input ent_raw_t r,
                                      input int sw,
                                      input int gw);
    ent_t e;
    e.to    = FLD_W'(r & fmask(sw));
    e.dir   = |((r >> sw) & ent_raw_t'(1));
    e.idx   = FLD_W'((r >> (sw + 1)) & fmask(gw));
    e.from  = FLD_W'((r >> (sw + 1 + gw)) & fmask(sw));
    e.valid = |((r >> (2 * sw + 1 + gw)) & ent_raw_t'(1));
    return e;
  endfunction

endpackage

// File: rtl/sg_trans_lookup.sv
// sg_monitor transition table search: lowest-index hit for one
// (state, signal, direction) plus per-state enabled edge vectors.
module sg_trans_lookup
  import sg_mon_pkg::*;
#(
  parameter int N_SIG   = 4,
  parameter int N_STATE = 16,
  parameter int N_TRANS = 32,
  parameter logic [N_TRANS*ent_w(state_w(N_STATE), sig_w(N_SIG))-1:0]
    TRANS = '0
) (
  input  logic [state_w(N_STATE)-1:0] state_i,
  input  logic [sig_w(N_SIG)-1:0]     idx_i,
  input  logic                        dir_i,
  output logic                        hit_o,
  output logic [state_w(N_STATE)-1:0] to_o,
  output logic [N_SIG-1:0]            can_rise_o,
  output logic [N_SIG-1:0]            can_fall_o
);

  localparam int SW = state_w(N_STATE);
  localparam int GW = sig_w(N_SIG);
  localparam int EW = ent_w(SW, GW);

  ent_t e;

  // scan high to low so the lowest matching entry wins
  always_comb begin
    e          = '0;
    hit_o      = 1'b0;
    to_o       = '0;
    can_rise_o = '0;
    can_fall_o = '0;
    for (int i = N_TRANS - 1; i >= 0; i--) begin
      e = ent_unpack(ent_raw_t'(TRANS[i*EW +: EW]), SW, GW);
      if (e.valid && e.from == FLD_W'(state_i)) begin
        for (int j = 0; j < N_SIG; j++) begin
          if (e.idx == FLD_W'(j)) begin
            if (e.dir == DIR_RISE) can_rise_o[j] = 1'b1;
            else                   can_fall_o[j] = 1'b1;
          end
        end
        if (e.idx == FLD_W'(idx_i) && e.dir == dir_i) begin
          hit_o = 1'b1;
          to_o  = SW'(e.to);
        end
      end
    end
  end

endmodule

// File: rtl/sg_monitor.sv
// sg_monitor: state-graph protocol monitor tracking single-signal
// edges through a transition table and recording violations.
module sg_monitor
  import sg_mon_pkg::*;
#(
  parameter int N_SIG      = 4,
  parameter int N_STATE    = 16,
  parameter int N_TRANS    = 32,
  parameter int N_ENA      = 4,
  parameter int CNT_W      = 8,
  parameter int INIT_STATE = 0,
  parameter logic [N_SIG-1:0] OUT_MASK = '0,
  parameter bit HALT_ON_ERR = 1'b0,
  parameter logic [N_TRANS*ent_w(state_w(N_STATE), sig_w(N_SIG))-1:0]
    TRANS = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_ENA-1:0]            ena,
  input  logic [N_SIG-1:0]            sig,
  input  logic                        clear,
  output logic [state_w(N_STATE)-1:0] state,
  output logic [N_SIG-1:0]            can_rise,
  output logic [N_SIG-1:0]            can_fall,
  output logic                        in_viol,
  output logic                        out_viol,
  output logic                        multi_err,
  output logic                        ena_err,
  output logic                        halted,
  output logic [CNT_W-1:0]            viol_cnt,
  output logic [sig_w(N_SIG)-1:0]     first_sig,
  output logic                        first_dir,
  output logic [state_w(N_STATE)-1:0] first_state
);

  localparam int STATE_W = state_w(N_STATE);
  localparam int SIG_W   = sig_w(N_SIG);

  logic [N_SIG-1:0]   prev_q;
  logic               primed_q;
  logic [STATE_W-1:0] state_q, state_d;
  logic               in_viol_q, in_viol_d;
  logic               out_viol_q, out_viol_d;
  logic               multi_q, multi_d;
  logic               ena_err_q, ena_err_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_base;
  logic [SIG_W-1:0]   fsig_q, fsig_d;
  logic               fdir_q, fdir_d;
  logic [STATE_W-1:0] fst_q, fst_d;

  logic [N_SIG-1:0]   chg;
  logic               one_chg;
  logic               multi_chg;
  logic               ena_bad;
  logic [SIG_W-1:0]   chg_idx;
  logic               chg_dir;
  logic               hit;
  logic [STATE_W-1:0] hit_to;
  logic               miss;
  logic               in_v, out_v, multi_v, ena_v, viol;

  assign chg       = sig ^ prev_q;
  assign one_chg   = (chg != '0) &&
                     ((chg & (chg - N_SIG'(1))) == '0);
  assign multi_chg = (chg != '0) && !one_chg;
  assign ena_bad   = (ena & (ena - N_ENA'(1))) != '0;

  // lowest changed signal index and its new level
  always_comb begin
    chg_idx = '0;
    for (int i = N_SIG - 1; i >= 0; i--) begin
      if (chg[i]) chg_idx = SIG_W'(i);
    end
  end

  assign chg_dir = sig[chg_idx];

  sg_trans_lookup #(
    .N_SIG   (N_SIG),
    .N_STATE (N_STATE),
    .N_TRANS (N_TRANS),
    .TRANS   (TRANS)
  ) u_lookup (
    .state_i    (state_q),
    .idx_i      (chg_idx),
    .dir_i      (chg_dir),
    .hit_o      (hit),
    .to_o       (hit_to),
    .can_rise_o (can_rise),
    .can_fall_o (can_fall)
  );

  assign miss    = primed_q && one_chg && !hit;
  assign in_v    = miss && !OUT_MASK[chg_idx];
  assign out_v   = miss && OUT_MASK[chg_idx];
  assign multi_v = primed_q && multi_chg;
  assign ena_v   = primed_q && ena_bad;
  assign viol    = in_v || out_v || multi_v || ena_v;

  // next state, sticky flags, counter and first-violation capture
  always_comb begin
    cnt_base   = clear ? '0 : cnt_q;
    state_d    = state_q;
    in_viol_d  = (in_viol_q && !clear) || in_v;
    out_viol_d = (out_viol_q && !clear) || out_v;
    multi_d    = (multi_q && !clear) || multi_v;
    ena_err_d  = (ena_err_q && !clear) || ena_v;
    halted_d   = (halted_q && !clear) || (HALT_ON_ERR && viol);
    cnt_d      = cnt_base;
    fsig_d     = clear ? '0 : fsig_q;
    fdir_d     = clear ? 1'b0 : fdir_q;
    fst_d      = clear ? '0 : fst_q;
    if (primed_q && one_chg && hit && !halted_q) state_d = hit_to;
    if (viol && cnt_base != '1) cnt_d = cnt_base + CNT_W'(1);
    if (viol && cnt_base == '0) begin
      fsig_d = chg_idx;
      fdir_d = (chg != '0) && chg_dir;
      fst_d  = state_q;
    end
  end

  // state registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q     <= '0;
      primed_q   <= 1'b0;
      state_q    <= STATE_W'(INIT_STATE);
      in_viol_q  <= 1'b0;
      out_viol_q <= 1'b0;
      multi_q    <= 1'b0;
      ena_err_q  <= 1'b0;
      halted_q   <= 1'b0;
      cnt_q      <= '0;
      fsig_q     <= '0;
      fdir_q     <= 1'b0;
      fst_q      <= '0;
    end else begin
      prev_q     <= sig;
      primed_q   <= 1'b1;
      state_q    <= state_d;
      in_viol_q  <= in_viol_d;
      out_viol_q <= out_viol_d;
      multi_q    <= multi_d;
      ena_err_q  <= ena_err_d;
      halted_q   <= halted_d;
      cnt_q      <= cnt_d;
      fsig_q     <= fsig_d;
      fdir_q     <= fdir_d;
      fst_q      <= fst_d;
    end
  end

  assign state       = state_q;
  assign in_viol     = in_viol_q;
  assign out_viol    = out_viol_q;
  assign multi_err   = multi_q;
  assign ena_err     = ena_err_q;
  assign halted      = halted_q;
  assign viol_cnt    = cnt_q;
  assign first_sig   = fsig_q;
  assign first_dir   = fdir_q;
  assign first_state = fst_q;

endmodule

// File: tb/tb_sg_monitor.sv
// Bench for sg_monitor: 2-signal handshake graph
// 0 -a+-> 1 -b+-> 2 -a--> 3 -b--> 0, a = input, b = output.
module tb_sg_monitor;

  // entry = {valid, from[1:0], idx[0], dir, to[1:0]}
  localparam logic [6:0] E0 = {1'b1, 2'd0, 1'b0, 1'b1, 2'd1};
  localparam logic [6:0] E1 = {1'b1, 2'd1, 1'b1, 1'b1, 2'd2};
  localparam logic [6:0] E2 = {1'b1, 2'd2, 1'b0, 1'b0, 2'd3};
  localparam logic [6:0] E3 = {1'b1, 2'd3, 1'b1, 1'b0, 2'd0};
  localparam logic [27:0] TBL = {E3, E2, E1, E0};

  localparam int S_ST = 0, S_CR = 1, S_CF = 2, S_IV = 3;
  localparam int S_OV = 4, S_ME = 5, S_EE = 6, S_H = 7;
  localparam int S_CNT = 8, S_FS = 9, S_FD = 10, S_FST = 11;
  localparam int S_STB = 12, S_CNTB = 13, S_HB = 14, S_FSB = 15;

  logic       clk, reset, clear;
  logic [1:0] ena, sig;

  logic [1:0] st_a, cr_a, cf_a, fst_a;
  logic       iv_a, ov_a, me_a, ee_a, h_a, fs_a, fd_a;
  logic [7:0] cnt_a;

  logic [1:0] st_b, cr_b, cf_b, fst_b, cnt_b;
  logic       iv_b, ov_b, me_b, ee_b, h_b, fs_b, fd_b;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       nm;
  } sb_t;

  sb_t q[$];
  sb_t e;

  sg_monitor #(
    .N_SIG(2), .N_STATE(4), .N_TRANS(4), .N_ENA(2), .CNT_W(8),
    .INIT_STATE(0), .OUT_MASK(2'b10), .HALT_ON_ERR(1'b0),
    .TRANS(TBL)
  ) dut_a (
    .clk(clk), .reset(reset), .ena(ena), .sig(sig), .clear(clear),
    .state(st_a), .can_rise(cr_a), .can_fall(cf_a),
    .in_viol(iv_a), .out_viol(ov_a), .multi_err(me_a),
    .ena_err(ee_a), .halted(h_a), .viol_cnt(cnt_a),
    .first_sig(fs_a), .first_dir(fd_a), .first_state(fst_a)
  );

  sg_monitor #(
    .N_SIG(2), .N_STATE(4), .N_TRANS(4), .N_ENA(2), .CNT_W(2),
    .INIT_STATE(0), .OUT_MASK(2'b10), .HALT_ON_ERR(1'b1),
    .TRANS(TBL)
  ) dut_b (
    .clk(clk), .reset(reset), .ena(ena), .sig(sig), .clear(clear),
    .state(st_b), .can_rise(cr_b), .can_fall(cf_b),
    .in_viol(iv_b), .out_viol(ov_b), .multi_err(me_b),
    .ena_err(ee_b), .halted(h_b), .viol_cnt(cnt_b),
    .first_sig(fs_b), .first_dir(fd_b), .first_state(fst_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_ST:    return 32'(st_a);
      S_CR:    return 32'(cr_a);
      S_CF:    return 32'(cf_a);
      S_IV:    return 32'(iv_a);
      S_OV:    return 32'(ov_a);
      S_ME:    return 32'(me_a);
      S_EE:    return 32'(ee_a);
      S_H:     return 32'(h_a);
      S_CNT:   return 32'(cnt_a);
      S_FS:    return 32'(fs_a);
      S_FD:    return 32'(fd_a);
      S_FST:   return 32'(fst_a);
      S_STB:   return 32'(st_b);
      S_CNTB:  return 32'(cnt_b);
      S_HB:    return 32'(h_b);
      S_FSB:   return 32'(fs_b);
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic put(input int sel, input int v, input string nm);
    sb_t s;
    s.sel = sel;
    s.exp = 32'(v);
    s.nm  = nm;
    q.push_back(s);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sig   = 2'b00;
    ena   = 2'b00;
    clear = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sig   = 2'b00;
    ena   = 2'b00;
    clear = 1'b0;
    #1;
    put(S_ST, 0, "rst_state");
    put(S_IV, 0, "rst_in_viol");
    put(S_OV, 0, "rst_out_viol");
    put(S_ME, 0, "rst_multi");
    put(S_EE, 0, "rst_ena_err");
    put(S_H, 0, "rst_halted");
    put(S_CNT, 0, "rst_cnt");
    put(S_FST, 0, "rst_first_state");
    put(S_STB, 0, "rst_state_b");
    put(S_CR, 1, "rst_can_rise");
    put(S_CF, 0, "rst_can_fall");
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        failures++;
        $display("FAIL %s got=%0h exp=%0h", e.nm, obs(e.sel), e.exp);
      end
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_legal();
    logic [1:0] sv[4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    int st[4] = '{1, 2, 3, 0};
    int cr[4] = '{2, 0, 0, 1};
    int cf[4] = '{0, 1, 2, 0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sig = sv[i];
      tick();
      put(S_ST, st[i], $sformatf("legal_state_%0d", i));
      put(S_CR, cr[i], $sformatf("legal_can_rise_%0d", i));
      put(S_CF, cf[i], $sformatf("legal_can_fall_%0d", i));
      while (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (obs(e.sel) !== e.exp) begin
          failures++;
          $display("FAIL %s got=%0h exp=%0h", e.nm, obs(e.sel), e.exp);
        end
      end
    end
    put(S_IV, 0, "legal_in_viol");
    put(S_OV, 0, "legal_out_viol");
    put(S_ME, 0, "legal_multi");
    put(S_EE, 0, "legal_ena_err");
    put(S_CNT, 0, "legal_cnt");
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        failures++;
        $display("FAIL %s got=%0h exp=%0h", e.nm, obs(e.sel), e.exp);
      end
    end
  endtask

  task automatic test_out_viol();
    do_reset();
    sig = 2'b10;
    tick();
    put(S_OV, 1, "ov_out_viol");
    put(S_IV, 0, "ov_in_viol");
    put(S_ST, 0, "ov_state");
    put(S_FS, 1, "ov_first_sig");
    put(S_FD, 1, "ov_first_dir");
    put(S_FST, 0, "ov_first_state");
    put(S_CNT, 1, "ov_cnt");
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        failures++;
        $display("FAIL %s got=%0h exp=%0h", e.nm, obs(e.sel), e.exp);
      end
    end
  endtask

  task automatic test_in_viol();
    do_reset();
    sig = 2'b01;
    tick();
    sig = 2'b00;
    tick();
    put(S_IV, 1, "iv_in_viol");
    put(S_OV, 0, "iv_out_viol");
    put(S_ST, 1, "iv_state");
    put(S_FS, 0, "iv_first_sig");
    put(S_FD, 0, "iv_first_dir");
    put(S_FST, 1, "iv_first_state");
    put(S_CNT, 1, "iv_cnt");
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        failures++;
        $display("FAIL %s got=%0h exp=%0h", e.nm, obs(e.sel), e.exp);
      end
    end
  endtask

  task automatic test_multi();
    do_reset();
    sig = 2'b11;
    tick();
    put(S_ME, 1, "multi_flag");
    put(S_FS, 0, "multi_first_sig");
    put(S_FD, 1, "multi_first_dir");
    put(S_ST, 0, "multi_state");
    put(S_CNT, 1, "multi_cnt");
    put(S_IV, 0, "multi_in_viol");
    put(S_OV, 0, "multi_out_viol");
    tick();
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        failures++;
        $display("FAIL %s got=%0h exp=%0h", e.nm, obs(e.sel), e.exp);
      end
    end
  endtask

  task automatic test_ena_clear();
    do_reset();
    ena = 2'b11;
    tick();
    ena = 2'b00;
    put(S_EE, 1, "ena_err_set");
    put(S_CNT, 1, "ena_cnt");
    put(S_ST, 0, "ena_state");
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        failures++;
        $display("FAIL %s got=%0h exp=%0h", e.nm, obs(e.sel), e.exp);
      end
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    put(S_EE, 0, "clr_ena_err");
    put(S_CNT, 0, "clr_cnt");
    put(S_HB, 0, "clr_halted_b");
    put(S_CNTB, 0, "clr_cnt_b");
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        failures++;
        $display("FAIL %s got=%0h exp=%0h", e.nm, obs(e.sel), e.exp);
      end
    end
    ena = 2'b11;
    tick();
    ena = 2'b00;
    clear = 1'b1;
    sig = 2'b10;
    tick();
    clear = 1'b0;
    put(S_EE, 0, "clrviol_ena_err");
    put(S_OV, 1, "clrviol_out_viol");
    put(S_CNT, 1, "clrviol_cnt");
    put(S_FS, 1, "clrviol_first_sig");
    put(S_FD, 1, "clrviol_first_dir");
    put(S_FST, 0, "clrviol_first_state");
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        failures++;
        $display("FAIL %s got=%0h exp=%0h", e.nm, obs(e.sel), e.exp);
      end
    end
  endtask

  task automatic test_saturate_halt();
    logic [1:0] sv[5] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sig = sv[i];
      tick();
    end
    put(S_CNTB, 3, "sat_cnt_b");
    put(S_HB, 1, "sat_halted_b");
    put(S_CNT, 5, "sat_cnt_a");
    put(S_H, 0, "sat_halted_a");
    put(S_FSB, 1, "sat_first_sig_b");
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        failures++;
        $display("FAIL %s got=%0h exp=%0h", e.nm, obs(e.sel), e.exp);
      end
    end
    sig = 2'b00;
    tick();
    sig = 2'b01;
    tick();
    put(S_ST, 1, "halt_state_a_moves");
    put(S_STB, 0, "halt_state_b_frozen");
    put(S_CNTB, 3, "halt_cnt_b_held");
    put(S_CNT, 6, "halt_cnt_a");
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        failures++;
        $display("FAIL %s got=%0h exp=%0h", e.nm, obs(e.sel), e.exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    sig = 2'b01;
    tick();
    sig = 2'b11;
    tick();
    put(S_ST, 2, "mid_pre_state");
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        failures++;
        $display("FAIL %s got=%0h exp=%0h", e.nm, obs(e.sel), e.exp);
      end
    end
    reset = 1'b1;
    #1;
    put(S_ST, 0, "mid_async_state");
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        failures++;
        $display("FAIL %s got=%0h exp=%0h", e.nm, obs(e.sel), e.exp);
      end
    end
    tick();
    reset = 1'b0;
    tick();
    put(S_ME, 0, "mid_prime_multi");
    put(S_CNT, 0, "mid_prime_cnt");
    put(S_ST, 0, "mid_prime_state");
    tick();
    put(S_ME, 0, "mid_after_multi");
    put(S_CNT, 0, "mid_after_cnt");
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (obs(e.sel) !== e.exp) begin
        failures++;
        $display("FAIL %s got=%0h exp=%0h", e.nm, obs(e.sel), e.exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    sig   = 2'b00;
    ena   = 2'b00;
    clear = 1'b0;
    test_reset();
    test_legal();
    test_out_viol();
    test_in_viol();
    test_multi();
    test_ena_clear();
    test_saturate_halt();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
